// File: rtl/ram_mmio.sv
// Byte-addressed little-endian data memory with a small memory-mapped I/O window
// (LED, free-running timer, synchronised buttons, scratch) and a registered read port.
module ram_mmio #(
  parameter int unsigned MEM_BYTES = 4096,
  parameter string       INIT_FILE = "",
  parameter logic [11:0] IO_BASE   = 12'hFFF,
  parameter int unsigned LED_WIDTH = 4,
  parameter int unsigned BTN_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 re,
  input  logic [1:0]           we,
  input  logic [31:0]          addr,
  input  logic [31:0]          wd,
  output logic [31:0]          rdata,
  output logic                 rd_valid,
  output logic                 err,
  output logic [LED_WIDTH-1:0] led,
  input  logic [BTN_WIDTH-1:0] btn
);
  localparam int unsigned AW        = $clog2(MEM_BYTES);
  localparam int unsigned DEPTH     = MEM_BYTES / 4;
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  typedef enum logic [1:0] {SRC_ZERO, SRC_MEM, SRC_IO} rd_src_e;

  // Four byte-lane banks so an unaligned word touches each bank exactly once.
  logic [7:0]    mem_q [4][DEPTH];
  logic [7:0]    lane_rd_q [4];
  logic [AW-3:0] lane_idx [4];
  logic [7:0]    lane_wbyte [4];
  logic [3:0]    lane_we;
  logic [31:0]   mem_word;

  logic [31:0]          led_q, led_d;
  logic [31:0]          timer_q, timer_d;
  logic [31:0]          scratch_q, scratch_d;
  logic [31:0]          io_rdata_q, io_rdata_d;
  logic [BTN_WIDTH-1:0] btn_s1_q, btn_s2_q;
  rd_src_e              rd_src_q, rd_src_d;
  logic [1:0]           rd_off_q;
  logic                 rd_valid_q;
  logic                 err_q, err_d;

  logic        rd_req, wr_req, io_sel, io_mapped;
  logic [1:0]  io_reg, size_m1;
  logic [31:0] wmask, io_val;
  logic        mem_rd_ok, mem_wr_ok, io_rd_ok, io_wr_ok, mem_wr;

  // Requests on a reset edge are dropped entirely.
  assign rd_req    = re & ~rst;
  assign wr_req    = (we != 2'b00) & ~rst;
  assign io_sel    = (addr[31:20] == IO_BASE);
  assign io_mapped = (addr[1:0] == 2'b00) && (addr[19:4] == 16'd0);
  assign io_reg    = addr[3:2];

  always_comb begin
    size_m1 = 2'd0;
    wmask   = 32'h0000_00FF;
    case (we)
      2'b10: begin
        size_m1 = 2'd1;
        wmask   = 32'h0000_FFFF;
      end
      2'b11: begin
        size_m1 = 2'd3;
        wmask   = 32'hFFFF_FFFF;
      end
      default: ;
    endcase
  end

  // Reads are always checked as full words; 33-bit sums avoid wrap at the top of the space.
  assign mem_rd_ok = !io_sel && (({1'b0, addr} + 33'd3) < MEM_LIMIT);
  assign mem_wr_ok = !io_sel && (({1'b0, addr} + {31'd0, size_m1}) < MEM_LIMIT);
  assign io_rd_ok  = io_sel && io_mapped;
  assign io_wr_ok  = io_sel && io_mapped && (io_reg != 2'd2);
  assign mem_wr    = wr_req && mem_wr_ok;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [1:0] lane_off;
      logic       wrap;
      // lane_off: which byte of the access lands in this bank; wrap: it lives in the next word row.
      assign lane_off        = 2'(gi) - addr[1:0];
      assign wrap            = (2'(gi) < addr[1:0]);
      assign lane_idx[gi]    = addr[AW-1:2] + {{(AW-3){1'b0}}, wrap};
      assign lane_we[gi]     = mem_wr && (lane_off <= size_m1);
      assign lane_wbyte[gi]  = wd[8*lane_off +: 8];
      assign mem_word[8*gi +: 8] = lane_rd_q[rd_off_q + 2'(gi)];
    end
  endgenerate

  // Read-before-write falls out of the synchronous read sampling the old contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (lane_we[b]) mem_q[b][lane_idx[b]] <= lane_wbyte[b];
      lane_rd_q[b] <= mem_q[b][lane_idx[b]];
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  always_comb begin
    case (io_reg)
      2'd0:    io_val = led_q;
      2'd1:    io_val = timer_q;
      2'd2:    io_val = 32'(btn_s2_q);
      default: io_val = scratch_q;
    endcase
  end

  always_comb begin
    led_d     = led_q;
    timer_d   = timer_q + 32'd1;
    scratch_d = scratch_q;
    if (wr_req && io_wr_ok) begin
      case (io_reg)
        2'd0:    led_d     = merge(led_q, wd, wmask);
        2'd1:    timer_d   = merge(timer_q, wd, wmask);
        2'd3:    scratch_d = merge(scratch_q, wd, wmask);
        default: ;
      endcase
    end
    rd_src_d   = SRC_ZERO;
    io_rdata_d = 32'd0;
    if (rd_req) begin
      if (mem_rd_ok) begin
        rd_src_d = SRC_MEM;
      end else if (io_rd_ok) begin
        rd_src_d   = SRC_IO;
        io_rdata_d = io_val;
      end
    end
    err_d = (rd_req && !(mem_rd_ok || io_rd_ok)) || (wr_req && !(mem_wr_ok || io_wr_ok));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q      <= 32'd0;
      timer_q    <= 32'd0;
      scratch_q  <= 32'd0;
      io_rdata_q <= 32'd0;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      rd_src_q   <= SRC_ZERO;
      rd_off_q   <= 2'd0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      led_q      <= led_d;
      timer_q    <= timer_d;
      scratch_q  <= scratch_d;
      io_rdata_q <= io_rdata_d;
      btn_s1_q   <= btn;
      btn_s2_q   <= btn_s1_q;
      rd_src_q   <= rd_src_d;
      rd_off_q   <= addr[1:0];
      rd_valid_q <= rd_req;
      err_q      <= err_d;
    end
  end

  always_comb begin
    case (rd_src_q)
      SRC_MEM: rdata = mem_word;
      SRC_IO:  rdata = io_rdata_q;
      default: rdata = 32'd0;
    endcase
  end

  assign rd_valid = rd_valid_q;
  assign err      = err_q;
  assign led      = led_q[LED_WIDTH-1:0];

endmodule

// File: tb/tb_ram_mmio.sv
// Directed and random checks of ram_mmio against an access-level model of memory,
// I/O registers, timer and button synchroniser.
module tb_ram_mmio;
  localparam int MEMB = 4096;
  localparam logic [31:0] IOB = 32'hFFF0_0000;

  logic        clk = 1'b0;
  logic        rst, re;
  logic [1:0]  we;
  logic [31:0] addr, wd, rdata;
  logic        rd_valid, err;
  logic [3:0]  led, btn;

  ram_mmio #(.MEM_BYTES(MEMB), .INIT_FILE(""), .IO_BASE(12'hFFF), .LED_WIDTH(4), .BTN_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .wd(wd),
    .rdata(rdata), .rd_valid(rd_valid), .err(err), .led(led), .btn(btn)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  m_mem [MEMB];
  logic [31:0] m_led, m_timer, m_scratch;
  logic [3:0]  m_s1, m_s2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] io_reg_val(input logic [1:0] r);
    case (r)
      2'd0:    return m_led;
      2'd1:    return m_timer;
      2'd2:    return {28'd0, m_s2};
      default: return m_scratch;
    endcase
  endfunction

  // One clock: drive a request, advance the model by one access, compare outputs.
  task automatic step(input logic r, input logic [1:0] w, input logic [31:0] a,
                      input logic [31:0] d, input string tag);
    logic [31:0] exp_rd, mask, nt;
    bit          rej_r, rej_w, is_io;
    int          size;
    longint      la;
    la     = longint'(a);
    is_io  = (a[31:20] == 12'hFFF);
    exp_rd = 32'd0;
    rej_r  = 1'b0;
    rej_w  = 1'b0;
    if (r) begin
      if (is_io) begin
        if (a[1:0] != 2'b00 || a[19:0] > 20'hC) rej_r = 1'b1;
        else exp_rd = io_reg_val(a[3:2]);
      end else if (la + 3 >= MEMB) rej_r = 1'b1;
      else for (int k = 0; k < 4; k++) exp_rd[8*k +: 8] = m_mem[int'(la) + k];
    end
    size = (w == 2'b01) ? 1 : (w == 2'b10) ? 2 : 4;
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    nt   = m_timer + 32'd1;
    if (w != 2'b00) begin
      if (is_io) begin
        if (a[1:0] != 2'b00 || a[19:0] > 20'hC || a[3:2] == 2'd2) rej_w = 1'b1;
        else if (a[3:2] == 2'd0) m_led = (m_led & ~mask) | (d & mask);
        else if (a[3:2] == 2'd1) nt = (m_timer & ~mask) | (d & mask);
        else m_scratch = (m_scratch & ~mask) | (d & mask);
      end else if (la + size - 1 >= MEMB) rej_w = 1'b1;
      else for (int k = 0; k < size; k++) m_mem[int'(la) + k] = d[8*k +: 8];
    end
    re = r; we = w; addr = a; wd = d;
    @(posedge clk);
    #1;
    m_timer = nt;
    m_s2 = m_s1;
    m_s1 = btn;
    chk({tag, ".rd_valid"}, {31'd0, rd_valid}, {31'd0, r});
    if (r) chk({tag, ".rdata"}, rdata, exp_rd);
    chk({tag, ".err"}, {31'd0, err}, {31'd0, (r & rej_r) | ((w != 2'b00) & rej_w)});
    chk({tag, ".led"}, {28'd0, led}, {28'd0, m_led[3:0]});
    re = 1'b0; we = 2'b00;
  endtask

  task automatic do_reset(input logic r, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    rst = 1'b1; re = r; we = w; addr = a; wd = d;
    @(posedge clk);
    #1;
    m_led = 0; m_timer = 0; m_scratch = 0; m_s1 = 0; m_s2 = 0;
    chk("reset.rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset.err", {31'd0, err}, 32'd0);
    chk("reset.led", {28'd0, led}, 32'd0);
    chk("reset.rdata", rdata, 32'd0);
    rst = 1'b0; re = 1'b0; we = 2'b00;
  endtask

  initial begin
    logic [31:0] ra;
    rst = 1'b1; re = 1'b0; we = 2'b00; addr = 32'd0; wd = 32'd0; btn = 4'h0;
    for (int i = 0; i < MEMB; i++) m_mem[i] = 8'h00;
    do_reset(1'b0, 2'b00, 32'd0, 32'd0);
    for (int i = 0; i < MEMB / 4; i++) step(1'b0, 2'b11, 32'(i * 4), 32'd0, "zero_fill");

    // Timer counts cycles from reset; read at the 10th edge sees 9.
    do_reset(1'b0, 2'b00, 32'd0, 32'd0);
    for (int i = 0; i < 9; i++) step(1'b0, 2'b00, 32'd0, 32'd0, "idle");
    step(1'b1, 2'b00, IOB + 32'h4, 32'd0, "timer_rd");
    chk("timer_edge10", rdata, 32'd9);

    step(1'b0, 2'b11, 32'h10, 32'hDEADBEEF, "word_wr");
    step(1'b1, 2'b00, 32'h10, 32'd0, "word_rd");
    chk("word_rd_const", rdata, 32'hDEADBEEF);
    step(1'b1, 2'b00, 32'h11, 32'd0, "unaligned_rd");
    chk("unaligned_rd_const", rdata, 32'h00DEADBE);

    step(1'b0, 2'b01, 32'h20, 32'h000000AA, "byte_wr");
    step(1'b0, 2'b10, 32'h21, 32'h00001234, "half_wr");
    step(1'b1, 2'b00, 32'h20, 32'd0, "bh_rd");
    chk("bh_rd_const", rdata, 32'h001234AA);

    step(1'b0, 2'b11, IOB, 32'h5, "led_wr");
    chk("led_word", {28'd0, led}, 32'h5);
    step(1'b1, 2'b01, IOB, 32'hFFFF_FFF3, "led_byte");
    chk("led_byte_led", {28'd0, led}, 32'h3);
    step(1'b1, 2'b00, IOB, 32'd0, "led_rd");
    chk("led_rd_const", rdata, 32'hF3);

    step(1'b0, 2'b11, IOB + 32'h4, 32'hFFFF_FFFF, "timer_wr");
    step(1'b0, 2'b00, 32'd0, 32'd0, "idle");
    step(1'b1, 2'b00, IOB + 32'h4, 32'd0, "timer_wrap");
    chk("timer_wrap_const", rdata, 32'd0);

    step(1'b0, 2'b11, 32'(MEMB - 4), 32'h11223344, "top_wr");
    step(1'b0, 2'b11, 32'(MEMB - 2), 32'hCAFEF00D, "oor_wr");
    step(1'b1, 2'b00, 32'(MEMB - 4), 32'd0, "oor_unchanged");
    chk("oor_unchanged_const", rdata, 32'h11223344);
    step(1'b1, 2'b00, 32'(MEMB - 3), 32'd0, "oor_rd");
    step(1'b1, 2'b00, IOB + 32'h2, 32'd0, "io_misalign_rd");
    chk("io_misalign_err", {31'd0, err}, 32'd1);
    step(1'b0, 2'b11, IOB + 32'h8, 32'h5, "btn_wr");
    chk("btn_wr_err", {31'd0, err}, 32'd1);
    step(1'b1, 2'b11, IOB + 32'h10, 32'h5, "unmapped");

    step(1'b0, 2'b11, 32'h40, 32'h7, "rw_setup");
    step(1'b1, 2'b11, 32'h40, 32'h1, "rw_same");
    chk("rw_same_const", rdata, 32'h7);
    step(1'b1, 2'b00, 32'h40, 32'd0, "rw_after");
    chk("rw_after_const", rdata, 32'h1);

    btn = 4'hA;
    step(1'b1, 2'b00, IOB + 32'h8, 32'd0, "btn_e1");
    step(1'b1, 2'b00, IOB + 32'h8, 32'd0, "btn_e2");
    step(1'b1, 2'b00, IOB + 32'h8, 32'd0, "btn_e3");
    chk("btn_e3_const", rdata, 32'hA);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) ra = IOB + 32'($urandom_range(0, 20));
      else ra = 32'($urandom_range(0, MEMB + 4));
      if ($urandom_range(0, 15) == 0) btn = 4'($urandom);
      step(1'($urandom), 2'($urandom), ra, $urandom, "rand");
    end

    step(1'b0, 2'b11, IOB + 32'h4, 32'h50, "timer_set");
    step(1'b0, 2'b11, IOB, 32'hF, "led_set");
    step(1'b0, 2'b11, 32'h40, 32'h1, "mem_set");
    do_reset(1'b1, 2'b11, 32'h40, 32'h99);
    step(1'b1, 2'b00, IOB + 32'h4, 32'd0, "timer_post_rst");
    chk("timer_post_rst_const", rdata, 32'd0);
    step(1'b1, 2'b00, 32'h40, 32'd0, "mem_kept");
    chk("mem_kept_const", rdata, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
